// File: rtl/sevenseg_display_arbiter.sv
// Round-robin arbiter that shares one 8-digit seven-segment display among four requesters,
// with a minimum dwell per owner and a blanked gap on every ownership change.
module sevenseg_display_arbiter #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned CW    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] digits0,
  input  logic [31:0] digits1,
  input  logic [31:0] digits2,
  input  logic [31:0] digits3,
  input  logic [7:0]  en0,
  input  logic [7:0]  en1,
  input  logic [7:0]  en2,
  input  logic [7:0]  en3,
  output logic [3:0]  grant,
  output logic [31:0] DIGITS,
  output logic [7:0]  EN,
  output logic        busy
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned EW   = 8;
  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [EW-1:0]   en_q, en_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   pick;
  logic [DW-1:0]   own_digits;
  logic [EW-1:0]   own_en;
  logic            leave;

  // First requester at or after ptr; scanning k downward lets the smallest k win.
  always_comb begin
    pick = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[ptr_q + IW'(k)]) pick = ptr_q + IW'(k);
    end
  end

  always_comb begin
    own_digits = digits0;
    own_en     = en0;
    case (owner_q)
      2'd0: begin own_digits = digits0; own_en = en0; end
      2'd1: begin own_digits = digits1; own_en = en1; end
      2'd2: begin own_digits = digits2; own_en = en2; end
      2'd3: begin own_digits = digits3; own_en = en3; end
      default: ;
    endcase
  end

  // Release by the owner takes precedence; preemption only once the dwell has saturated.
  assign leave = !req[owner_q] || ((cnt_q == DWELL_C) && (|(req & ~grant_q)));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    digits_d = digits_q;
    en_d     = en_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        en_d = '1;
        if (|req) begin
          state_d = OWN;
          owner_d = pick;
          grant_d = NREQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        digits_d = own_digits;
        en_d     = own_en;
        if (cnt_q != DWELL_C) cnt_d = cnt_q + CW'(1);
        if (leave) begin
          grant_d = '0;
          state_d = GAP;
          ptr_d   = owner_q + IW'(1);
        end
      end
      GAP: begin
        en_d    = '1;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        en_d    = '1;
      end
    endcase
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      digits_q <= '0;
      en_q     <= '1;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      digits_q <= digits_d;
      en_q     <= en_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign grant  = grant_q;
  assign DIGITS = digits_q;
  assign EN     = en_q;
  assign busy   = busy_q;

endmodule
